pkt_fifo: RTL and testbench
===========================

// Module: pkt_fifo
// PURPOSE
// - Parametrised packet-aware FIFO with store-and-forward semantics; buffers whole Ethernet frames between MAC RX and the switch fabric.
// - Write side is speculative: a frame becomes visible to the reader only when its last word is committed.
// - Frames can be discarded by the writer (bad FCS), and are auto-dropped on overflow.
// - Adds fill level, packet count, almost-full and drop reporting.
// PARAMETERS
// - WIDTH      8    data word width in bits
// - DEPTH      16   entries; must be a power of 2, >= 4
// - AF_LEVEL   12   almost_full asserts when fill >= AF_LEVEL (1..DEPTH)
// PORTS
// - clk         in   1             clock, all logic on posedge
// - rst         in   1             reset, asynchronous, active-high
// - wr_en       in   1             write strobe
// - wr_data     in   WIDTH         write data
// - wr_last     in   1             marks final word of frame
// - wr_drop     in   1             discard current uncommitted frame
// - rd_en       in   1             read strobe
// - rd_data     out  WIDTH         read data, registered
// - rd_last     out  1             last flag of rd_data word, registered
// - rd_valid    out  1             rd_data/rd_last valid this cycle
// - empty       out  1             no committed word available
// - full        out  1             no free entry (committed+uncommitted)
// - almost_full out  1             fill >= AF_LEVEL
// - fill        out  $clog2(DEPTH)+1   entries occupied incl. uncommitted
// - pkt_count   out  $clog2(DEPTH)+1   committed frames not yet fully read
// - drop_pulse  out  1             1-cycle pulse per dropped frame
// BEHAVIOUR
// - Reset (async, rst=1): all pointers 0, pkt_count 0, ovf 0; outputs rd_data=0, rd_last=0, rd_valid=0, empty=1, full=0, almost_full=0, fill=0, drop_pulse=0.
// - Pointers are AW+1 bits (AW=$clog2(DEPTH)) with wrap-bit; index = low AW bits; natural wrap at 2*DEPTH.
// - Three pointers: wr_ptr (speculative), cm_ptr (commit), rd_ptr.
// - RAM word = {last, data}.
// - Flags are combinational from registered pointers:
//   - empty = (rd_ptr == cm_ptr)
//   - fill = wr_ptr - rd_ptr
//   - full = (fill == DEPTH)
// - Write accept: wr_en & !full & !ovf & !wr_drop. Stores {wr_last, wr_data}; wr_ptr += 1.
//   - If wr_last: cm_ptr <= wr_ptr+1 and pkt_count += 1, visible next cycle.
// - wr_drop: wr_ptr <= cm_ptr, ovf <= 0, drop_pulse next cycle.
//   - Same-cycle wr_en/wr_last are ignored; drop wins.
// - Overflow: wr_en & full & !wr_drop sets ovf; the word is discarded.
//   - While ovf=1 all writes are discarded.
//   - On wr_en & wr_last with ovf=1: wr_ptr <= cm_ptr, ovf <= 0, drop_pulse.
// - Read: rd_en & !empty reads mem[rd_ptr]; rd_ptr += 1; rd_data/rd_last/rd_valid update next cycle (latency 1).
//   - If the word read has last=1: pkt_count -= 1.
//   - rd_en & empty: no effect; rd_valid=0; rd_data holds.
// - Simultaneous commit and last-word read: pkt_count unchanged.
// - Simultaneous write and read: both proceed; full/fill use pre-edge pointers, so a write is refused if full even when a read frees space that cycle.
// - A frame longer than free space always overflows and is dropped; never deadlocks.
// - Reset mid-frame discards all content, including committed frames.
// STRUCTURE
// - Package pkt_fifo_pkg: function ptr_w(depth); typedef of {last,data} entry struct parametrised by localparam in module.
// - Sub-module sdp_ram (simple dual-port, 1 write port, 1 registered read port, no reset on array).
// - Top holds pointers, ovf, counters, flags.
// TESTING
// - Reset, write 3-word frame (last on 3rd): empty stays 1 until cycle after word 3, then pkt_count=1, fill=3; 3 reads give rd_last only on 3rd, empty=1 after.
// - Write 2 words, assert wr_drop: fill returns 0, drop_pulse once, empty=1 throughout, pkt_count=0.
// - DEPTH=16: write 20-word frame into empty FIFO: full at 16, ovf, on last word fill=0, drop_pulse=1, following 4-word frame commits normally.
// - Wrap: 10 cycles of 5-word frame write+read back-to-back: data matches in order, pointer wrap transparent, pkt_count never exceeds 2.
// - Same-cycle commit of frame B and last-word read of frame A: pkt_count unchanged; almost_full toggles at fill 11->12.
// - Assert rst mid-read with rd_valid=1: outputs to reset values immediately (async).

Source files
------------

// File: rtl/pkt_fifo_pkg.sv
// Shared helpers for the packet FIFO: pointer width derivation.
package pkt_fifo_pkg;

  // Pointer width: index bits plus one wrap bit, so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// The array has no reset. The read register resets so that rd_data starts at zero.
module sdp_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Hold the last read word unless a new read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pkt_fifo.sv
// Store-and-forward packet FIFO. Frames are written speculatively and become
// readable only once their last word commits. A frame can be discarded by the
// writer, and a frame that overflows the FIFO is dropped automatically.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_last,
  input  logic                   wr_drop,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_last,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] fill,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   drop_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    cm_ptr_q, cm_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    pkt_count_q, pkt_count_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;
  logic             rd_valid_q, rd_valid_d;
  // Copy of each entry's last flag, readable in the same cycle the word is popped.
  logic [DEPTH-1:0] last_vec_q, last_vec_d;

  logic             wr_accept;
  logic             commit;
  logic             rd_fire;
  logic             rd_dec;
  logic [PW-1:0]    fill_s;
  entry_t           wr_entry;
  entry_t           rd_entry;

  assign fill_s      = wr_ptr_q - rd_ptr_q;
  assign empty       = (rd_ptr_q == cm_ptr_q);
  assign full        = (fill_s == PW'(DEPTH));
  assign almost_full = (fill_s >= PW'(AF_LEVEL));
  assign fill        = fill_s;
  assign pkt_count   = pkt_count_q;
  assign drop_pulse  = drop_q;
  assign rd_valid    = rd_valid_q;

  assign rd_fire  = rd_en & ~empty;
  assign rd_dec   = rd_fire & last_vec_q[rd_ptr_q[AW-1:0]];
  assign wr_entry = '{last: wr_last, data: wr_data};

  // Write side: accept, commit, drop and overflow handling.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    ovf_d      = ovf_q;
    drop_d     = 1'b0;
    wr_accept  = 1'b0;
    commit     = 1'b0;
    last_vec_d = last_vec_q;
    if (wr_drop) begin
      wr_ptr_d = cm_ptr_q;
      ovf_d    = 1'b0;
      drop_d   = 1'b1;
    end else if (wr_en) begin
      if (ovf_q) begin
        if (wr_last) begin
          wr_ptr_d = cm_ptr_q;
          ovf_d    = 1'b0;
          drop_d   = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (full) begin
        // A last word that overflows ends its frame at once; otherwise arm ovf
        // and discard until the frame's last word arrives.
        if (wr_last) begin
          wr_ptr_d = cm_ptr_q;
          drop_d   = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        wr_accept                     = 1'b1;
        wr_ptr_d                      = wr_ptr_q + PW'(1);
        last_vec_d[wr_ptr_q[AW-1:0]]  = wr_last;
        if (wr_last) begin
          cm_ptr_d = wr_ptr_q + PW'(1);
          commit   = 1'b1;
        end else begin
          cm_ptr_d = cm_ptr_q;
        end
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Read side pointer, valid strobe and committed-frame counter.
  always_comb begin
    rd_ptr_d   = rd_ptr_q + (rd_fire ? PW'(1) : PW'(0));
    rd_valid_d = rd_fire;
    case ({commit, rd_dec})
      2'b10:   pkt_count_d = pkt_count_q + PW'(1);
      2'b01:   pkt_count_d = pkt_count_q - PW'(1);
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // Pointer, counter and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      last_vec_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
      rd_valid_q  <= rd_valid_d;
      last_vec_q  <= last_vec_d;
    end
  end

  sdp_ram #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_accept),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_entry),
    .re    (rd_fire),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_entry)
  );

  assign rd_data = rd_entry.data;
  assign rd_last = rd_entry.last;

endmodule

// File: tb/tb_pkt_fifo.sv
// Self-checking bench for pkt_fifo (WIDTH=8, DEPTH=16, AF_LEVEL=12).
// An integer-count reference model predicts flags. Committed frames go into a
// scoreboard queue, which is popped and compared whenever a read fires.
module tb_pkt_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       wr_drop;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] fill;
  logic [4:0] pkt_count;
  logic       drop_pulse;

  pkt_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_drop     (wr_drop),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .fill        (fill),
    .pkt_count   (pkt_count),
    .drop_pulse  (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         mw, mc, mr, mpc;
  bit         movf;
  logic [8:0] sb[$];
  logic [8:0] pend[$];
  logic [7:0] e_data;
  logic       e_last;
  int         pc_max;
  int         drops_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mw = 0; mc = 0; mr = 0; mpc = 0; movf = 1'b0;
    sb.delete(); pend.delete();
    e_data = 8'h00; e_last = 1'b0;
  endtask

  task automatic drop_frame();
    mw = mc; movf = 1'b0; pend.delete();
  endtask

  // One clock: drive inputs, predict, then compare every output after the edge.
  task automatic cyc(input logic we, input logic [7:0] wd, input logic wl,
                     input logic wdrop, input logic re);
    int mfill;
    bit mfull, mempty, e_valid, e_drop;
    logic [8:0] w;
    @(negedge clk);
    wr_en = we; wr_data = wd; wr_last = wl; wr_drop = wdrop; rd_en = re;
    mfill = mw - mr; mfull = (mfill == 16); mempty = (mr == mc);
    e_valid = 1'b0; e_drop = 1'b0;
    if (wdrop) begin
      drop_frame(); e_drop = 1'b1;
    end else if (we) begin
      if (movf || mfull) begin
        if (wl) begin
          drop_frame(); e_drop = 1'b1;
        end else begin
          movf = 1'b1;
        end
      end else begin
        pend.push_back({wl, wd});
        mw++;
        if (wl) begin
          mc = mw; mpc++;
          while (pend.size() > 0) sb.push_back(pend.pop_front());
        end
      end
    end
    if (re && !mempty) begin
      w = sb.pop_front(); mr++; e_valid = 1'b1;
      e_data = w[7:0]; e_last = w[8];
      if (w[8]) mpc--;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(e_valid));
    chk("rd_data", 32'(rd_data), 32'(e_data));
    chk("rd_last", 32'(rd_last), 32'(e_last));
    chk("fill", 32'(fill), 32'(mw - mr));
    chk("empty", 32'(empty), 32'(mr == mc));
    chk("full", 32'(full), 32'((mw - mr) == 16));
    chk("almost_full", 32'(almost_full), 32'((mw - mr) >= 12));
    chk("pkt_count", 32'(pkt_count), 32'(mpc));
    chk("drop_pulse", 32'(drop_pulse), 32'(e_drop));
    if (int'(pkt_count) > pc_max) pc_max = int'(pkt_count);
    if (drop_pulse) drops_seen++;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_frame(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) cyc(1'b1, base + 8'(i), 1'(i == len - 1), 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (mr != mc); i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("drained", 32'(mr == mc), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({pfx, "_rd_last"}, 32'(rd_last), 32'd0);
    chk({pfx, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({pfx, "_empty"}, 32'(empty), 32'd1);
    chk({pfx, "_full"}, 32'(full), 32'd0);
    chk({pfx, "_almost_full"}, 32'(almost_full), 32'd0);
    chk({pfx, "_fill"}, 32'(fill), 32'd0);
    chk({pfx, "_pkt_count"}, 32'(pkt_count), 32'd0);
    chk({pfx, "_drop_pulse"}, 32'(drop_pulse), 32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0; wr_drop = 1'b0; rd_en = 1'b0;
    model_reset();
    pc_max = 0; drops_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;

    // 3-word frame, then 3 reads
    write_frame(3, 8'h10);
    chk("f3_pkt", 32'(pkt_count), 32'd1);
    chk("f3_fill", 32'(fill), 32'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("f3_last", 32'(rd_last), 32'd1);
    chk("f3_empty", 32'(empty), 32'd1);
    idle();

    // 2 words then writer drop
    drops_seen = 0;
    cyc(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h23, 1'b1, 1'b1, 1'b0);
    idle(); idle();
    chk("drop_count", 32'(drops_seen), 32'd1);

    // 20-word frame overflows and is dropped; 4-word frame follows normally
    drops_seen = 0;
    write_frame(20, 8'h40);
    chk("ovf_fill0", 32'(fill), 32'd0);
    chk("ovf_drop", 32'(drops_seen), 32'd1);
    write_frame(4, 8'h80);
    chk("post_ovf_pkt", 32'(pkt_count), 32'd1);
    drain();

    // Back-to-back write and read over many pointer wraps
    pc_max = 0;
    for (int f = 0; f < 10; f++)
      for (int i = 0; i < 5; i++)
        cyc(1'b1, 8'(f * 16 + i), 1'(i == 4), 1'b0, 1'b1);
    drain();
    chk("wrap_pc_max_le2", 32'(pc_max <= 2), 32'd1);

    // Commit of B in the same cycle as the last-word read of A
    write_frame(3, 8'hA0);
    cyc(1'b1, 8'hB0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hB1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hB2, 1'b1, 1'b0, 1'b1);
    chk("commit_read_pkt", 32'(pkt_count), 32'd1);
    drain();

    // almost_full crossing at 11 -> 12
    write_frame(11, 8'hC0);
    chk("af_at11", 32'(almost_full), 32'd0);
    cyc(1'b1, 8'hCB, 1'b0, 1'b0, 1'b0);
    chk("af_at12", 32'(almost_full), 32'd1);
    cyc(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    drain();

    // Asynchronous reset while rd_valid is high
    write_frame(3, 8'hD0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
